pe_seq_controller: RTL and testbench

//  Sequencing FSM for the 8-bit processing-element counter (Start_Pe/En_Cnt1 in, Cnt1_Out/CO1 out).
//  On a Start pulse it clears the counter, then issues one Pe_Req/Pe_Ack transaction per count

---
 rtl/pe_seq_controller_if.sv | 32 +++
 rtl/pe_seq_controller.sv | 63 ++++++
 tb/tb_pe_seq_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_controller_if.sv
// rtl/pe_seq_controller_if.sv - control, counter and PE handshake bundle for pe_seq_controller
interface pe_seq_controller_if #(
  parameter int CNT_W = 8
);
  // Top-level control
  logic             Start;
  logic [CNT_W-1:0] Limit;
  logic             Abort;
  logic             Busy;
  logic             Done;
  logic             Aborted;
  // Counter side
  logic [CNT_W-1:0] Cnt1_Out;
  logic             CO1;
  logic             Start_Pe;
  logic             En_Cnt1;
  // PE datapath handshake
  logic             Pe_Req;
  logic             Pe_Ack;

  // The sequencer drives the counter controls, the PE request and the status flags.
  modport master (
    input  Start, Limit, Abort, Cnt1_Out, CO1, Pe_Ack,
    output Start_Pe, En_Cnt1, Pe_Req, Busy, Done, Aborted
  );

  // The surrounding control, counter and datapath.
  modport slave (
    output Start, Limit, Abort, Cnt1_Out, CO1, Pe_Ack,
    input  Start_Pe, En_Cnt1, Pe_Req, Busy, Done, Aborted
  );
endinterface

// File: rtl/pe_seq_controller.sv
// rtl/pe_seq_controller.sv - run sequencer for the PE counter: clear, request per count, step
module pe_seq_controller #(
  parameter int CNT_W = 8
) (
  input logic              Clk,
  input logic              Rst,
  pe_seq_controller_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ABRT = 3'd5;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] limit_q;
  logic             last;

  // The terminal-count term stops the run at the counter's top value even if
  // limit_q disagrees, so the counter is never asked to wrap.
  assign last = (bus.Cnt1_Out == limit_q) | bus.CO1;

  // Next-state decode; Abort has priority over Pe_Ack in every active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Start) state_d = S_INIT;
      S_INIT: state_d = bus.Abort ? S_ABRT : S_REQ;
      S_REQ: begin
        if (bus.Abort)       state_d = S_ABRT;
        else if (bus.Pe_Ack) state_d = last ? S_DONE : S_GAP;
      end
      S_GAP:  state_d = bus.Abort ? S_ABRT : S_REQ;
      S_DONE: state_d = S_IDLE;
      S_ABRT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops straight to IDLE so every output clears at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Limit is latched only when a run is accepted, so later Limit changes are ignored.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                               limit_q <= '0;
    else if (state_q == S_IDLE && bus.Start) limit_q <= bus.Limit;
  end

  // Moore outputs, decoded from the state register only.
  assign bus.Start_Pe = (state_q == S_INIT);
  assign bus.Pe_Req   = (state_q == S_REQ);
  assign bus.En_Cnt1  = (state_q == S_GAP);
  assign bus.Busy     = (state_q == S_INIT) | (state_q == S_REQ) | (state_q == S_GAP);
  assign bus.Done     = (state_q == S_DONE);
  assign bus.Aborted  = (state_q == S_ABRT);

endmodule

// File: tb/tb_pe_seq_controller.sv
// tb/tb_pe_seq_controller.sv - directed bench for pe_seq_controller with an 8-bit counter model
module tb_pe_seq_controller;

  logic Clk;
  logic Rst;

  pe_seq_controller_if #(.CNT_W(8)) itf ();

  pe_seq_controller #(.CNT_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (itf)
  );

  always #5 Clk = ~Clk;

  // Counter under control: synchronous clear on Start_Pe, increment on En_Cnt1.
  logic [7:0] cnt;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)               cnt <= 8'd0;
    else if (itf.Start_Pe) cnt <= 8'd0;
    else if (itf.En_Cnt1)  cnt <= cnt + 8'd1;
  end
  assign itf.Cnt1_Out = cnt;
  assign itf.CO1      = (cnt == 8'hFF);

  int checks = 0;
  int errors = 0;

  int         n_cyc, reqs, ens, spes, dones, aborts, done_cyc, abort_cyc, busy_after;
  bit         ended;
  logic [7:0] last_req_cnt;
  logic       last_req_co1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run: pulse Start, then watch outputs at each falling edge until Done/Aborted
  // plus three idle cycles. mode 0 = Pe_Ack held high, mode 1 = random 0-5 cycle delay.
  // abort_req != 0 asserts Abort together with Pe_Ack on that REQ.
  // poke_start pulses Start/Limit=1 mid-run and Start again in the Done/Aborted cycle.
  task automatic run_seq(input logic [7:0] lim, input int mode, input int abort_req,
                         input bit poke_start, input int budget);
    int wait_left;
    bit req_seen;
    bit prev_req;
    bit rose;
    int post;
    n_cyc = 0; reqs = 0; ens = 0; spes = 0; dones = 0; aborts = 0;
    done_cyc = 0; abort_cyc = 0; busy_after = 0; ended = 0;
    last_req_cnt = 8'd0; last_req_co1 = 1'b0;
    wait_left = 0; req_seen = 0; prev_req = 0; post = 0;
    @(negedge Clk);
    itf.Start  = 1'b1;
    itf.Limit  = lim;
    itf.Abort  = 1'b0;
    itf.Pe_Ack = (mode == 0);
    while (n_cyc < budget && post < 3) begin
      @(negedge Clk);
      n_cyc++;
      itf.Start = 1'b0;
      itf.Abort = 1'b0;
      if (n_cyc == 1) itf.Limit = ~lim;
      if (poke_start && n_cyc == 4) begin
        itf.Start = 1'b1;
        itf.Limit = 8'd1;
      end
      if (ended) begin
        post++;
        if (itf.Busy || itf.Start_Pe || itf.Pe_Req) busy_after++;
      end
      if (itf.Start_Pe) spes++;
      if (itf.En_Cnt1)  ens++;
      rose = itf.Pe_Req && !prev_req;
      if (rose) begin
        reqs++;
        last_req_cnt = itf.Cnt1_Out;
        last_req_co1 = itf.CO1;
      end
      prev_req = itf.Pe_Req;
      if (itf.Done)    begin dones++;  done_cyc  = n_cyc; end
      if (itf.Aborted) begin aborts++; abort_cyc = n_cyc; end
      if (itf.Done || itf.Aborted) begin
        if (poke_start) itf.Start = 1'b1;
        ended = 1'b1;
      end
      if (mode == 0) begin
        itf.Pe_Ack = 1'b1;
      end else if (!itf.Pe_Req) begin
        req_seen   = 1'b0;
        itf.Pe_Ack = 1'b0;
      end else begin
        if (!req_seen) begin
          req_seen  = 1'b1;
          wait_left = $urandom_range(0, 5);
        end
        if (wait_left == 0) itf.Pe_Ack = 1'b1;
        else begin
          itf.Pe_Ack = 1'b0;
          wait_left--;
        end
      end
      if (abort_req != 0 && rose && reqs == abort_req) begin
        itf.Abort  = 1'b1;
        itf.Pe_Ack = 1'b1;
      end
    end
    itf.Start = 1'b0;
    itf.Abort = 1'b0;
    chk("run_ended", ended, 1);
  endtask

  initial begin
    Clk = 1'b0;
    Rst = 1'b0;
    itf.Start = 1'b0; itf.Limit = 8'd0; itf.Abort = 1'b0; itf.Pe_Ack = 1'b0;
    #1 Rst = 1'b1;
    @(negedge Clk);
    chk("rst_start_pe", itf.Start_Pe, 0);
    chk("rst_en_cnt1",  itf.En_Cnt1, 0);
    chk("rst_pe_req",   itf.Pe_Req, 0);
    chk("rst_busy",     itf.Busy, 0);
    chk("rst_done",     itf.Done, 0);
    chk("rst_aborted",  itf.Aborted, 0);
    Rst = 1'b0;

    // Abort and Pe_Ack in IDLE have no effect.
    itf.Abort = 1'b1; itf.Pe_Ack = 1'b1;
    @(negedge Clk);
    chk("idle_abort_busy",    itf.Busy, 0);
    @(negedge Clk);
    chk("idle_abort_aborted", itf.Aborted, 0);
    itf.Abort = 1'b0;

    // 1: Limit=3, ack held high.
    run_seq(8'd3, 0, 0, 1'b0, 100);
    chk("t1_start_pe", spes, 1);
    chk("t1_reqs",     reqs, 4);
    chk("t1_ens",      ens, 3);
    chk("t1_cnt",      itf.Cnt1_Out, 3);
    chk("t1_done_cyc", done_cyc, 9);
    chk("t1_dones",    dones, 1);
    chk("t1_aborts",   aborts, 0);

    // 2: Limit=0.
    run_seq(8'd0, 0, 0, 1'b0, 100);
    chk("t2_reqs",     reqs, 1);
    chk("t2_ens",      ens, 0);
    chk("t2_done_cyc", done_cyc, 3);
    chk("t2_cnt",      itf.Cnt1_Out, 0);

    // 3: Limit=255, random ack delay, no wrap.
    run_seq(8'd255, 1, 0, 1'b0, 4000);
    chk("t3_reqs",      reqs, 256);
    chk("t3_ens",       ens, 255);
    chk("t3_last_cnt",  last_req_cnt, 255);
    chk("t3_last_co1",  last_req_co1, 1);
    chk("t3_dones",     dones, 1);
    chk("t3_cnt",       itf.Cnt1_Out, 255);

    // 4: Limit=9, Abort together with Pe_Ack on the 3rd REQ.
    run_seq(8'd9, 0, 3, 1'b0, 100);
    chk("t4_reqs",       reqs, 3);
    chk("t4_ens",        ens, 2);
    chk("t4_cnt",        itf.Cnt1_Out, 2);
    chk("t4_aborts",     aborts, 1);
    chk("t4_abort_cyc",  abort_cyc, 7);
    chk("t4_dones",      dones, 0);
    chk("t4_busy_after", busy_after, 0);

    // 5: Limit=5, Start/Limit=1 poked mid-run and in the Done cycle.
    run_seq(8'd5, 0, 0, 1'b1, 100);
    chk("t5_reqs",       reqs, 6);
    chk("t5_ens",        ens, 5);
    chk("t5_cnt",        itf.Cnt1_Out, 5);
    chk("t5_done_cyc",   done_cyc, 13);
    chk("t5_dones",      dones, 1);
    chk("t5_start_pe",   spes, 1);
    chk("t5_busy_after", busy_after, 0);

    // 6: asynchronous reset during GAP, then a clean run.
    @(negedge Clk);
    itf.Start = 1'b1; itf.Limit = 8'd5; itf.Pe_Ack = 1'b1;
    @(negedge Clk);
    itf.Start = 1'b0;
    for (int i = 0; i < 20 && !itf.En_Cnt1; i++) @(negedge Clk);
    chk("t6_in_gap", itf.En_Cnt1, 1);
    #2 Rst = 1'b1;
    #1;
    chk("t6_rst_outs", {itf.Start_Pe, itf.En_Cnt1, itf.Pe_Req, itf.Busy, itf.Done, itf.Aborted}, 0);
    @(negedge Clk);
    chk("t6_rst_hold_busy", itf.Busy, 0);
    Rst = 1'b0;
    run_seq(8'd2, 0, 0, 1'b0, 100);
    chk("t6_reqs",     reqs, 3);
    chk("t6_ens",      ens, 2);
    chk("t6_done_cyc", done_cyc, 7);
    chk("t6_cnt",      itf.Cnt1_Out, 2);
    chk("t6_aborts",   aborts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
